// File: rtl/vga_text_console.sv
// Byte-stream text console feeding vga_adapter: decodes ASCII/control bytes into
// display-buffer writes, tracks the cursor and blanks lines/screen on demand.
module vga_text_console #(
  parameter int         COLS       = 50,
  parameter int         ROWS       = 30,
  parameter logic [6:0] BLANK_CHAR = 7'h20
) (
  input  logic        clk_20_mhz,
  input  logic        reset_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [10:0] address,
  output logic [6:0]  char_input,
  output logic        write_enable,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [1:0]  ST_IDLE         = 2'd0;
  localparam logic [1:0]  ST_CLEAR_LINE   = 2'd1;
  localparam logic [1:0]  ST_CLEAR_SCREEN = 2'd2;

  localparam logic [10:0] LAST_CELL = 11'(COLS * ROWS - 1);
  localparam logic [10:0] COLS_A    = 11'(COLS);
  localparam logic [5:0]  LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  logic [1:0]  state;
  logic [10:0] clr_cnt;
  logic [10:0] clr_end;
  logic [10:0] row_base;      // always equals cursor_row*COLS, kept incrementally

  logic        accept;
  logic        is_print;
  logic        newline;
  logic        row_wrap;
  logic [10:0] cell_addr;
  logic [10:0] next_row_base;

  assign accept        = char_valid && char_ready && (state == ST_IDLE);
  assign is_print      = (char_in >= 8'h20) && (char_in <= 8'h7E);
  assign newline       = accept && ((is_print && (cursor_col == LAST_COL)) || (char_in == 8'h0A));
  assign row_wrap      = (cursor_row == LAST_ROW);
  assign cell_addr     = row_base + {5'd0, cursor_col};
  assign next_row_base = row_wrap ? 11'd0 : row_base + COLS_A;

  always_ff @(posedge clk_20_mhz or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_CLEAR_SCREEN;
      clr_cnt      <= 11'd0;
      clr_end      <= LAST_CELL;
      row_base     <= 11'd0;
      cursor_col   <= 6'd0;
      cursor_row   <= 5'd0;
      address      <= 11'd0;
      char_input   <= 7'd0;
      write_enable <= 1'b0;
      char_ready   <= 1'b0;
      busy         <= 1'b1;
    end else begin
      write_enable <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_print) begin
              write_enable <= 1'b1;
              address      <= cell_addr;
              char_input   <= char_in[6:0];
              cursor_col   <= cursor_col + 6'd1;
            end else begin
              case (char_in)
                8'h0D: cursor_col <= 6'd0;
                8'h08: begin
                  // No reverse wrap: backspace at column 0 does nothing
                  if (cursor_col != 6'd0) begin
                    cursor_col   <= cursor_col - 6'd1;
                    write_enable <= 1'b1;
                    address      <= cell_addr - 11'd1;
                    char_input   <= BLANK_CHAR;
                  end
                end
                8'h0C: begin
                  cursor_col <= 6'd0;
                  cursor_row <= 5'd0;
                  row_base   <= 11'd0;
                  clr_cnt    <= 11'd0;
                  clr_end    <= LAST_CELL;
                  state      <= ST_CLEAR_SCREEN;
                  char_ready <= 1'b0;
                  busy       <= 1'b1;
                end
                default: ;
              endcase
            end
            // Line advance overrides the column increment above
            if (newline) begin
              cursor_col <= 6'd0;
              cursor_row <= row_wrap ? 5'd0 : cursor_row + 5'd1;
              row_base   <= next_row_base;
              clr_cnt    <= next_row_base;
              clr_end    <= next_row_base + COLS_A - 11'd1;
              state      <= ST_CLEAR_LINE;
              char_ready <= 1'b0;
              busy       <= 1'b1;
            end
          end
        end
        ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
          write_enable <= 1'b1;
          address      <= clr_cnt;
          char_input   <= BLANK_CHAR;
          clr_cnt      <= clr_cnt + 11'd1;
          if (clr_cnt == clr_end) begin
            state      <= ST_IDLE;
            char_ready <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= ST_CLEAR_SCREEN;
          clr_cnt    <= 11'd0;
          clr_end    <= LAST_CELL;
          char_ready <= 1'b0;
          busy       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_text_console.sv
// Bench for vga_text_console: queue-based console model checked every cycle,
// plus directed byte sequences with hand-computed expectations.
module tb_vga_text_console;

  logic        clk_20_mhz = 1'b0;
  logic        reset_n    = 1'b0;
  logic [7:0]  char_in    = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [10:0] address;
  logic [6:0]  char_input;
  logic        write_enable;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  vga_text_console dut (
    .clk_20_mhz  (clk_20_mhz),
    .reset_n     (reset_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .address     (address),
    .char_input  (char_input),
    .write_enable(write_enable),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  always #25 clk_20_mhz = ~clk_20_mhz;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                 name, actual, actual, expected, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int a; int c; } wr_t;
  wr_t q[$];
  int  m_col = 0, m_row = 0, m_addr = 0, m_ch = 0;
  bit  m_we = 1'b0, m_ready = 1'b0;

  function automatic void push_blanks(input int first, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.a = first + i;
      w.c = 32'h20;
      q.push_back(w);
    end
  endfunction

  function automatic void model_newline();
    m_col = 0;
    m_row = (m_row + 1) % 30;
    push_blanks(m_row * 50, 50);
  endfunction

  always @(posedge clk_20_mhz or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      push_blanks(0, 1500);
      m_col = 0; m_row = 0; m_we = 1'b0; m_addr = 0; m_ch = 0; m_ready = 1'b0;
    end else begin
      int b;
      wr_t w;
      m_we = 1'b0;
      if (char_valid && m_ready) begin
        b = int'(char_in);
        if (b >= 32'h20 && b <= 32'h7E) begin
          m_we = 1'b1; m_addr = m_row * 50 + m_col; m_ch = b;
          if (m_col < 49) m_col++;
          else model_newline();
        end else if (b == 32'h0A) model_newline();
        else if (b == 32'h0D) m_col = 0;
        else if (b == 32'h08) begin
          if (m_col > 0) begin
            m_col--; m_we = 1'b1; m_addr = m_row * 50 + m_col; m_ch = 32'h20;
          end
        end else if (b == 32'h0C) begin
          m_col = 0; m_row = 0;
          push_blanks(0, 1500);
        end
      end else if (q.size() > 0) begin
        w = q.pop_front();
        m_we = 1'b1; m_addr = w.a; m_ch = w.c;
      end
      m_ready = (q.size() == 0);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_20_mhz) begin
    if (checking) begin
      check("cyc_we", int'(write_enable), int'(m_we));
      if (m_we) begin
        check("cyc_addr", int'(address), m_addr);
        check("cyc_char", int'(char_input), m_ch);
      end
      check("cyc_ready", int'(char_ready), int'(m_ready));
      check("cyc_busy", int'(busy), int'(!m_ready));
      check("cyc_col", int'(cursor_col), m_col);
      check("cyc_row", int'(cursor_row), m_row);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        s_we;
  logic [10:0] s_addr;
  logic [6:0]  s_ch;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    do begin
      @(negedge clk_20_mhz);
      n++;
    end while (!char_ready && n < 3000);
    if (!char_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      char_in    = b;
      char_valid = 1'b1;
      @(negedge clk_20_mhz);
      char_valid = 1'b0;
    end
    s_we = write_enable; s_addr = address; s_ch = char_input;
  endtask

  task automatic count_clear(output int n, output int first);
    int w = 0;
    n = 0; first = -1;
    do begin
      @(negedge clk_20_mhz);
      w++;
    end while (!write_enable && w < 10);
    if (write_enable) first = int'(address);
    while (write_enable && n < 3000) begin
      n++;
      @(negedge clk_20_mhz);
    end
  endtask

  initial begin
    int n, first, w;
    repeat (3) @(negedge clk_20_mhz);
    checking = 1'b1;
    check("rst_we", int'(write_enable), 0);
    check("rst_ready", int'(char_ready), 0);
    check("rst_busy", int'(busy), 1);
    #5 reset_n = 1'b1;

    count_clear(n, first);
    check("init_clear_len", n, 1500);
    check("init_clear_first", first, 0);
    check("init_ready", int'(char_ready), 1);
    check("init_cursor", int'({cursor_row, cursor_col}), 0);

    send_byte(8'h48);
    check("H_write", int'({s_we, s_addr, s_ch}), int'({1'b1, 11'd0, 7'h48}));
    send_byte(8'h69);
    check("i_write", int'({s_we, s_addr, s_ch}), int'({1'b1, 11'd1, 7'h69}));
    check("hi_col", int'(cursor_col), 2);

    send_byte(8'h0D);
    check("cr_nowrite", int'(s_we), 0);
    for (int i = 0; i < 50; i++) send_byte(8'(8'h61 + i % 26));
    check("row_last_write", int'({s_we, s_addr}), int'({1'b1, 11'd49}));
    check("wrap_cursor", int'({cursor_row, cursor_col}), int'({5'd1, 6'd0}));
    count_clear(n, first);
    check("line_clear_len", n, 50);
    check("line_clear_first", first, 50);

    for (int i = 0; i < 28; i++) send_byte(8'h0A);
    w = 0;
    while (!char_ready && w < 100) begin @(negedge clk_20_mhz); w++; end
    check("at_row29", int'(cursor_row), 29);
    send_byte(8'h0A);
    check("lf_nowrite", int'(s_we), 0);
    check("lf_wrap_cursor", int'({cursor_row, cursor_col}), 0);
    count_clear(n, first);
    check("row0_clear_first", first, 0);
    check("row0_clear_len", n, 50);

    for (int i = 0; i < 7; i++) send_byte(8'h78);
    check("col7", int'(cursor_col), 7);
    send_byte(8'h0D);
    check("cr_col7_nowrite", int'(s_we), 0);
    check("cr_col7_col", int'(cursor_col), 0);

    send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    check("row2_col3", int'({cursor_row, cursor_col}), int'({5'd2, 6'd3}));
    send_byte(8'h08);
    check("bs_write", int'({s_we, s_addr, s_ch}), int'({1'b1, 11'd102, 7'h20}));
    check("bs_col", int'(cursor_col), 2);
    send_byte(8'h0D);
    send_byte(8'h08);
    check("bs_col0_nowrite", int'(s_we), 0);
    check("bs_col0_cursor", int'({cursor_row, cursor_col}), int'({5'd2, 6'd0}));

    send_byte(8'h80); check("discard_80", int'(s_we), 0);
    send_byte(8'h7F); check("discard_7f", int'(s_we), 0);
    send_byte(8'h01); check("discard_01", int'(s_we), 0);

    send_byte(8'h51); send_byte(8'h52);
    send_byte(8'h0C);
    check("ff_cursor", int'({cursor_row, cursor_col}), 0);
    w = 0;
    do begin @(negedge clk_20_mhz); w++; end
    while (!(write_enable && address == 11'd700) && w < 2000);
    check("ff_reached_700", int'(address), 700);
    #5 reset_n = 1'b0;
    #1;
    check("async_we_drop", int'(write_enable), 0);
    check("async_ready_drop", int'(char_ready), 0);
    repeat (3) @(negedge clk_20_mhz);
    #5 reset_n = 1'b1;
    count_clear(n, first);
    check("restart_clear_first", first, 0);
    check("restart_clear_len", n, 1500);
    check("restart_ready", int'(char_ready), 1);

    repeat (2) @(negedge clk_20_mhz);
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Upstream feeder for vga_adapter; converts a byte stream of ASCII characters and control codes into display-buffer writes.
- Drives the adapter's `address`, `char_input` and `write_enable` directly.
- Tracks a cursor over the 50-column x 30-row character grid (1500 cells, row-major, address = row*50 + col).
- Handles line wrap, newline, carriage return, backspace and form-feed, and blanks the buffer by writing the space code.

Parameters:
- COLS, 50, characters per row (400 px / 8 px glyph width).
- ROWS, 30, character rows (300 virtual lines / 10-line glyph height).
- BLANK_CHAR, 7'h20, code written when clearing cells.

Ports:
- clk_20_mhz  input  1  pixel clock shared with vga_adapter; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- char_in  input  8  incoming byte.
- char_valid  input  1  char_in is valid this cycle.
- char_ready  output  1  block can accept a byte this cycle.
- address  output  11  buffer cell address to vga_adapter.
- char_input  output  7  character code to vga_adapter.
- write_enable  output  1  one-cycle write strobe to vga_adapter.
- cursor_col  output  6  current cursor column, 0..COLS-1.
- cursor_row  output  5  current cursor row, 0..ROWS-1.
- busy  output  1  high while a line or screen clear is in progress.

Behaviour:
- Clock and reset: one clock, clk_20_mhz. reset_n is asynchronous and active-low.
- Reset values: state=CLEAR_SCREEN, clear counter=0, cursor_col=0, cursor_row=0, address=0, char_input=0, write_enable=0, char_ready=0, busy=1.
  - On release of reset the block performs a full-screen clear.
- Outputs: all registered; no combinational path from char_valid to any output.
- Accept: a byte is accepted on a posedge where char_valid && char_ready. char_ready=1 only in IDLE.
- Write strobe: write_enable, address and char_input update on the accepting edge. write_enable is high for exactly one cycle.
- State IDLE — byte decode:
  - 0x20..0x7E (printable): write code at row*COLS+col.
    - If col<COLS-1: col+1.
    - Else: col=0, row=(row+1) mod ROWS, enter CLEAR_LINE for the new row.
  - 0x0A (LF): col=0, row=(row+1) mod ROWS, enter CLEAR_LINE. No character write.
  - 0x0D (CR): col=0, no write.
  - 0x08 (BS):
    - If col>0: col-1 and write BLANK_CHAR at the new position.
    - If col=0: no write, no cursor change (no reverse line wrap).
  - 0x0C (FF): cursor to (0,0), enter CLEAR_SCREEN.
  - Any other byte (other controls, 0x7F, >=0x80): accepted and discarded, no write.
- State CLEAR_LINE:
  - char_ready=0, busy=1.
  - Writes BLANK_CHAR to addresses row*COLS+0 .. row*COLS+COLS-1 on 50 consecutive cycles, write_enable high each cycle.
  - After the last write, return to IDLE; char_ready=1 on the following cycle.
  - Wrap from row ROWS-1 clears row 0 (no scrolling; the buffer is write-only).
- State CLEAR_SCREEN:
  - Writes BLANK_CHAR to addresses 0..COLS*ROWS-1 (0..1499) on 1500 consecutive cycles, write_enable high each cycle.
  - Then return to IDLE.
- Address arithmetic:
  - Cell address computed as row*COLS+col in 11 bits; maximum 1499, never exceeds 1499.
  - Clear sequences use an incrementing 11-bit counter started at the row base, not a per-cycle multiply.
- Cursor outputs: cursor_col and cursor_row reflect the post-update cursor from the cycle after the accepting edge.
- Simultaneous events: char_valid asserted during a clear is ignored (not accepted). The byte must be held by the source until char_ready.
- Reset mid-operation:
  - Asserting reset_n low drops write_enable and char_ready immediately, asynchronously.
  - Any partial clear is abandoned; a full clear restarts after release.

Test Plan:
- Reset release -> write_enable high for 1500 consecutive cycles, addresses 0..1499, char_input=0x20. Then char_ready=1, cursor (0,0).
- Send 'H'(0x48) then 'i'(0x69) -> writes (addr 0, 0x48) and (addr 1, 0x69), one cycle each. cursor_col=2.
- Send 50 printable bytes from (0,0) -> last write at addr 49, cursor (0,1). 50-cycle clear of addrs 50..99 with char_ready=0.
- At row 29, send LF -> cursor (0,0), clear of addrs 0..49. Then CR at col 7 -> col 0, no write.
- BS at col 3 row 2 -> write 0x20 at addr 102, col=2. BS at col 0 -> no write, cursor unchanged.
- FF mid-line, then assert reset_n low at clear count 700 -> write_enable drops asynchronously. On release, a full 1500-write clear restarts from addr 0.
